disk_xfer_initiator: RTL and testbench

- Controller-side initiator for the block-storage command interface.
- Turns one multi-block transfer request (start block, word count, direction) into a sequence of single-block read_cmd/write_cmd handshakes toward a block device.
- Sources write words from the bus side into a local FIFO that the device drains. Forwards device read words to the bus side.
- Pads short final write blocks with zeros and discards excess words in short final read blocks.

---
 rtl/disk_pkg.sv | 7 +
 rtl/xfer_fifo.sv | 48 ++++
 rtl/disk_xfer_initiator.sv | 158 +++++++++++++++
 tb/tb_disk_xfer_initiator.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_pkg.sv
// disk_pkg: shared constants and state encoding for the block-storage initiator.
package disk_pkg;
    localparam int BLOCK_WORDS = 256;
    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 32;
    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/xfer_fifo.sv
// xfer_fifo: synchronous FIFO with flush; head word reads as zero when empty.
module xfer_fifo #(
    parameter int DEPTH = 512,
    parameter int W     = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]    mem_q [DEPTH];
    logic [CW-2:0]   rd_q, wr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign count_o = count_q;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/disk_xfer_initiator.sv
// disk_xfer_initiator: splits a multi-block transfer into single-block device commands.
// Define DISK_TIMEOUT_EN to add a per-phase handshake watchdog.
module disk_xfer_initiator
    import disk_pkg::*;
#(
    parameter int FIFO_DEPTH     = 512,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        is_write,
    input  logic [31:0] start_block,
    input  logic [15:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] dst_data,
    output logic        dst_valid,
    input  logic        command_ready,
    output logic        read_cmd,
    output logic        write_cmd,
    output logic [31:0] block_address,
    output logic [15:0] write_data,
    input  logic        write_data_enable,
    output logic        write_fifo_empty,
    input  logic [15:0] read_data,
    input  logic        read_data_enable
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic                is_write_q, cmd_q, abort_q, error_q, dst_valid_q;
    logic [ADDR_W-1:0]   start_block_q;
    logic [8:0]          nblocks_q, index_q, cnt_q, cnt_nx;
    logic [15:0]         src_rem_q, fwd_rem_q;
    logic [WORD_W-1:0]   dst_data_q, din;
    logic [7:0]          pad_q;
    logic [16:0]         wc_sum;
    logic [CW-1:0]       count;
    logic                start, strobe, blk_ok, more, timeout, fwd;
    logic                prod, pad, push, full, empty;

    assign start   = state_q == IDLE && go && !abort;
    assign wc_sum  = {1'b0, word_count} + 17'd255;
    assign strobe  = is_write_q ? (write_data_enable && !empty) : read_data_enable;
    assign cnt_nx  = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + {8'd0, strobe};
    assign blk_ok  = cnt_nx == 9'(BLOCK_WORDS);
    assign more    = (index_q + 9'd1) < nblocks_q;
    assign fwd     = read_data_enable && busy && !is_write_q && fwd_rem_q != '0;

    // Producer keeps filling during ISSUE/WAIT so the next block is ready early.
    assign prod      = busy && is_write_q && !abort_q;
    assign src_ready = prod && !full && src_rem_q != '0;
    assign pad       = prod && !full && src_rem_q == '0 && pad_q != '0;
    assign push      = (src_valid && src_ready) || pad;
    assign din       = src_rem_q != '0 ? src_data : '0;

`ifdef DISK_TIMEOUT_EN
    logic [15:0] tmr_q;
    assign timeout = (state_q == ISSUE || state_q == WAIT) && tmr_q == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) tmr_q <= '0;
        else tmr_q <= (state_d != state_q) ? 16'd0 : tmr_q + 16'd1;
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    xfer_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W), .CW(CW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (state_q == DONE),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (write_data_enable),
        .dout_o  (write_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = word_count == '0 ? DONE : is_write ? FILL : ISSUE;
            FILL:    if (abort) state_d = DONE;
                     else if (count >= CW'(BLOCK_WORDS)) state_d = ISSUE;
            ISSUE:   if (abort || timeout) state_d = DONE;
                     else if (cmd_q && !command_ready) state_d = WAIT;
            WAIT:    if (timeout) state_d = DONE;
                     else if (command_ready)
                         state_d = (abort_q || abort || !blk_ok || !more) ? DONE : is_write_q ? FILL : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q == FILL || state_q == ISSUE || state_q == WAIT;
        done      = state_q == DONE;
        read_cmd  = state_q == ISSUE && cmd_q && !is_write_q;
        write_cmd = state_q == ISSUE && cmd_q && is_write_q;
    end

    assign error            = error_q;
    assign dst_data         = dst_data_q;
    assign dst_valid        = dst_valid_q;
    assign block_address    = start_block_q + ADDR_W'(index_q);
    assign write_fifo_empty = empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_write_q    <= 1'b0;
            start_block_q <= '0;
            nblocks_q     <= '0;
            index_q       <= '0;
            src_rem_q     <= '0;
            fwd_rem_q     <= '0;
            pad_q         <= '0;
            cnt_q         <= '0;
            cmd_q         <= 1'b0;
            abort_q       <= 1'b0;
            error_q       <= 1'b0;
            dst_valid_q   <= 1'b0;
            dst_data_q    <= '0;
        end else begin
            if (start) begin
                is_write_q    <= is_write;
                start_block_q <= start_block;
                nblocks_q     <= wc_sum[16:8];
                index_q       <= '0;
                src_rem_q     <= is_write ? word_count : '0;
                fwd_rem_q     <= is_write ? '0 : word_count;
                pad_q         <= '0;
            end else begin
                if (push) pad_q <= pad_q + 8'd1;
                if (push && src_rem_q != '0) src_rem_q <= src_rem_q - 16'd1;
                if (fwd) fwd_rem_q <= fwd_rem_q - 16'd1;
                if (state_q == WAIT && (state_d == FILL || state_d == ISSUE)) index_q <= index_q + 9'd1;
            end
            // Command follows command_ready while issuing; dropping it is the device's accept.
            cmd_q       <= state_q == ISSUE && command_ready && !abort && !timeout;
            cnt_q       <= (state_q == ISSUE || (state_q == WAIT && state_d == WAIT)) ? cnt_nx : '0;
            abort_q     <= state_q == DONE ? 1'b0 : abort_q || (abort && state_q == WAIT);
            error_q     <= (start ? 1'b0 : error_q) | (write_data_enable && empty) | timeout
                         | (state_q == WAIT && command_ready && !abort_q && !abort && !blk_ok);
            dst_valid_q <= fwd;
            if (read_data_enable) dst_data_q <= read_data;
        end
    end
endmodule

// File: tb/tb_disk_xfer_initiator.sv
// tb_disk_xfer_initiator: randomized transfers against a device model and a queue-based reference.
module tb_disk_xfer_initiator;
    logic        clk = 1'b0;
    logic        reset, go, is_write, abort, src_valid, dev_cr, dev_hold;
    logic        read_data_enable, write_data_enable;
    logic [31:0] start_block;
    logic [15:0] word_count, src_data, read_data;
    wire         command_ready = dev_cr && !dev_hold;
    logic        busy, done, error, src_ready, dst_valid, read_cmd, write_cmd, write_fifo_empty;
    logic [15:0] dst_data, write_data;
    logic [31:0] block_address;

    int tests = 0, fails = 0;
    int done_n, src_acc, cmd_n, dev_fin, fin_at_done;
    int dev_words = 256;
    bit src_on = 0;
    logic [31:0] cmd_addr[$];
    bit          cmd_wr[$];
    logic [15:0] dst_q[$], dev_sent[$], cap_q[$], src_sent[$];

    disk_xfer_initiator dut (
        .clk(clk), .reset(reset), .go(go), .is_write(is_write), .start_block(start_block),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done), .error(error),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dst_data(dst_data), .dst_valid(dst_valid), .command_ready(command_ready),
        .read_cmd(read_cmd), .write_cmd(write_cmd), .block_address(block_address),
        .write_data(write_data), .write_data_enable(write_data_enable),
        .write_fifo_empty(write_fifo_empty), .read_data(read_data), .read_data_enable(read_data_enable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dst_valid) dst_q.push_back(dst_data);
        if (done) begin
            done_n++;
            fin_at_done = dev_fin;
        end
    end

    // Block device: accepts a command, streams dev_words words, then goes idle again.
    initial begin
        bit wr;
        dev_cr = 1; read_data_enable = 0; write_data_enable = 0; read_data = 0;
        forever begin
            @(negedge clk);
            if (command_ready && (read_cmd || write_cmd)) begin
                wr = write_cmd;
                cmd_n++;
                cmd_addr.push_back(block_address);
                cmd_wr.push_back(wr);
                @(posedge clk); #1 dev_cr = 0;
                for (int i = 0; i < dev_words; i++) begin
                    @(posedge clk); #1;
                    if (wr) write_data_enable = 1;
                    else begin
                        read_data = 16'($urandom);
                        read_data_enable = 1;
                        dev_sent.push_back(read_data);
                    end
                    @(negedge clk);
                    if (wr) cap_q.push_back(write_data);
                end
                @(posedge clk); #1;
                write_data_enable = 0; read_data_enable = 0; dev_cr = 1; dev_fin++;
            end
        end
    end

    initial begin
        bit acc;
        src_valid = 0; src_data = 0;
        forever begin
            @(negedge clk);
            acc = src_valid && src_ready;
            if (acc) begin
                src_acc++;
                src_sent.push_back(src_data);
            end
            @(posedge clk); #1;
            if (acc || !src_valid) src_data = 16'($urandom);
            src_valid = src_on && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic clear_logs();
        done_n = 0; src_acc = 0; cmd_n = 0; dev_fin = 0; fin_at_done = -1;
        cmd_addr.delete(); cmd_wr.delete(); dst_q.delete(); dev_sent.delete();
        cap_q.delete(); src_sent.delete();
    endtask

    task automatic start(input bit wr, input logic [31:0] sb, input logic [15:0] wc);
        @(posedge clk); #1;
        go = 1; is_write = wr; start_block = sb; word_count = wc; src_on = wr;
        @(posedge clk); #1 go = 0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (done_n > 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; go = 0; is_write = 0; abort = 0; start_block = 0; word_count = 0; dev_hold = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, done, error, src_ready, dst_valid, read_cmd, write_cmd, write_fifo_empty} !== 8'b0000_0001) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000001",
                     {busy, done, error, src_ready, dst_valid, read_cmd, write_cmd, write_fifo_empty});
        end
        tests++;
        if (block_address !== 32'd0) begin
            fails++;
            $display("FAIL reset_addr: got %h expected 0", block_address);
        end
        tests++;
        if (write_data !== 16'd0) begin
            fails++;
            $display("FAIL reset_wdata: got %h expected 0", write_data);
        end
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic run_xfer(input bit wr, input logic [31:0] sb, input logic [15:0] wc, input bit poke);
        bit ok;
        int nb, bad;
        logic [31:0] ea;
        clear_logs();
        dev_words = 256;
        nb = (int'(wc) + 255) / 256;
        start(wr, sb, wc);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_go: got %b expected 1", busy);
        end
        if (poke) begin
            for (int i = 0; i < 3000 && cmd_n < 1; i++) @(posedge clk);
            repeat (10) @(posedge clk);
            #1 go = 1; is_write = !wr; word_count = 5; start_block = ~sb;
            @(posedge clk); #1 go = 0;
        end
        wait_done(8000, ok);
        repeat (3) @(posedge clk);
        #1 src_on = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL xfer_done_seen: got 0 expected 1 (wr=%0d wc=%0d)", wr, wc);
        end
        tests++;
        if (done_n != 1 || error !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL xfer_status: got done_n=%0d error=%b busy=%b expected 1/0/0", done_n, error, busy);
        end
        tests++;
        if (cmd_n != nb) begin
            fails++;
            $display("FAIL xfer_cmd_count: got %0d expected %0d", cmd_n, nb);
        end
        bad = 0;
        for (int i = 0; i < cmd_addr.size(); i++) begin
            ea = sb + 32'(i);
            if (cmd_addr[i] !== ea || cmd_wr[i] != wr) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL xfer_cmd_addr: got %0d bad commands expected 0 (first addr %h, start %h)",
                     bad, cmd_addr.size() > 0 ? cmd_addr[0] : 32'hx, sb);
        end
        bad = 0;
        if (wr) begin
            for (int i = 0; i < cap_q.size(); i++)
                if (i < int'(wc) && i >= src_sent.size()) bad++;
                else if (cap_q[i] !== ((i < int'(wc)) ? src_sent[i] : 16'h0)) bad++;
            tests++;
            if (cap_q.size() != nb * 256 || src_acc != int'(wc)) begin
                fails++;
                $display("FAIL wr_counts: got %0d device words %0d accepts expected %0d / %0d",
                         cap_q.size(), src_acc, nb * 256, wc);
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL wr_data: got %0d wrong device words expected 0", bad);
            end
            tests++;
            if (write_fifo_empty !== 1'b1) begin
                fails++;
                $display("FAIL wr_fifo_empty: got %b expected 1", write_fifo_empty);
            end
        end else begin
            for (int i = 0; i < dst_q.size(); i++)
                if (i >= dev_sent.size() || dst_q[i] !== dev_sent[i]) bad++;
            tests++;
            if (dst_q.size() != int'(wc)) begin
                fails++;
                $display("FAIL rd_count: got %0d strobes expected %0d", dst_q.size(), wc);
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rd_data: got %0d wrong words expected 0", bad);
            end
        end
    endtask

    task automatic test_zero();
        clear_logs();
        start(0, 32'd7, 16'd0);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: got done=%b busy=%b expected 1/0", done, busy);
        end
        repeat (5) @(posedge clk);
        tests++;
        if (done_n != 1 || cmd_n != 0) begin
            fails++;
            $display("FAIL zero_quiet: got done_n=%0d cmds=%0d expected 1/0", done_n, cmd_n);
        end
    endtask

    task automatic test_short_block();
        bit ok;
        clear_logs();
        dev_words = 255;
        start(0, 32'd20, 16'd512);
        wait_done(3000, ok);
        repeat (20) @(posedge clk);
        tests++;
        if (!ok || error !== 1'b1 || done_n != 1) begin
            fails++;
            $display("FAIL short_err: got ok=%0d error=%b done_n=%0d expected 1/1/1", ok, error, done_n);
        end
        tests++;
        if (cmd_n != 1 || dst_q.size() != 255) begin
            fails++;
            $display("FAIL short_cmds: got cmds=%0d words=%0d expected 1/255", cmd_n, dst_q.size());
        end
        #1 dev_words = 256;
    endtask

    task automatic test_abort();
        bit ok;
        clear_logs();
        dev_words = 256;
        start(1, 32'd40, 16'd768);
        for (int i = 0; i < 4000 && !(cmd_n == 2 && dev_cr == 0); i++) @(posedge clk);
        tests++;
        if (!(cmd_n == 2 && dev_cr == 0)) begin
            fails++;
            $display("FAIL abort_reach_blk2: got cmds=%0d expected 2", cmd_n);
        end
        repeat (30) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        wait_done(1000, ok);
        repeat (60) @(posedge clk);
        #1 src_on = 0;
        tests++;
        if (!ok || done_n != 1 || fin_at_done != 2) begin
            fails++;
            $display("FAIL abort_done: got ok=%0d done_n=%0d blocks_finished_at_done=%0d expected 1/1/2",
                     ok, done_n, fin_at_done);
        end
        tests++;
        if (cmd_n != 2 || write_fifo_empty !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL abort_after: got cmds=%0d empty=%b error=%b expected 2/1/0",
                     cmd_n, write_fifo_empty, error);
        end
    endtask

    task automatic test_go_abort_idle();
        clear_logs();
        @(posedge clk); #1;
        go = 1; abort = 1; is_write = 0; word_count = 50; start_block = 3;
        @(posedge clk); #1 go = 0; abort = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_n != 0 || cmd_n != 0) begin
            fails++;
            $display("FAIL go_abort: got busy=%b done_n=%0d cmds=%0d expected 0/0/0", busy, done_n, cmd_n);
        end
    endtask

    task automatic test_hold();
        bit ok;
        clear_logs();
        dev_hold = 1;
        start(0, 32'd3, 16'd10);
        repeat (300) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || cmd_n != 0 || read_cmd !== 1'b0) begin
            fails++;
            $display("FAIL hold_busy: got busy=%b cmds=%0d read_cmd=%b expected 1/0/0", busy, cmd_n, read_cmd);
        end
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        wait_done(20, ok);
        @(negedge clk);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_abort: got done=%0d busy=%b expected 1/0", ok, busy);
        end
        #1 dev_hold = 0;
    endtask

    task automatic test_mid_reset();
        clear_logs();
        start(1, 32'd60, 16'd300);
        for (int i = 0; i < 3000 && !(cmd_n == 1 && dev_cr == 0); i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1 reset = 1; src_on = 0;
        @(negedge clk);
        tests++;
        if ({busy, write_cmd, write_fifo_empty, src_ready, done} !== 5'b00100) begin
            fails++;
            $display("FAIL midreset: got %b expected 00100", {busy, write_cmd, write_fifo_empty, src_ready, done});
        end
        @(posedge clk); #1 reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (error !== 1'b1 || write_data !== 16'h0) begin
            fails++;
            $display("FAIL underrun: got error=%b write_data=%h expected 1/0000", error, write_data);
        end
        for (int i = 0; i < 400 && dev_cr == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        run_xfer(0, 32'd5, 16'd512, 0);
        run_xfer(1, 32'd0, 16'd300, 0);
        run_xfer(0, 32'd9, 16'd10, 0);
        test_zero();
        test_short_block();
        test_abort();
        test_go_abort_idle();
        run_xfer(0, 32'd100, 16'd300, 1);
        for (int k = 0; k < 4; k++)
            run_xfer(1'($urandom_range(0, 1)), k == 0 ? 32'hFFFF_FFFF : $urandom,
                     16'($urandom_range(1, 700)), 0);
        test_hold();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
